// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage.
// Bypass logic is enabled by defining OPERAND_FETCH_BYPASS_EN.
package operand_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int CTRL_W    = 16;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic [CTRL_W-1:0]    ctrl;
    } side_t;

    function automatic logic idx_hit(
        input logic                 en,
        input logic [REG_IDX_W-1:0] wr,
        input logic [REG_IDX_W-1:0] rs
    );
        return en && (wr == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-source writeback capture register and operand mux.
// Active only when OPERAND_FETCH_BYPASS_EN is defined.
module operand_bypass
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 capture,
    input  logic                 track,
    input  logic [REG_IDX_W-1:0] new_idx,
    input  logic [REG_IDX_W-1:0] held_idx,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [XLEN-1:0]      rf_read,
    output logic [XLEN-1:0]      val
);

`ifdef OPERAND_FETCH_BYPASS_EN
    logic            byp_v;
    logic [XLEN-1:0] byp_d;

    // The register file returns the pre-write value on a same-edge
    // read/write, so a capture-time hit must override it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            byp_v <= 1'b0;
            byp_d <= '0;
        end else if (capture) begin
            if (idx_hit(wb_en, wb_rd, new_idx)) begin
                byp_v <= 1'b1;
                byp_d <= wb_data;
            end else begin
                byp_v <= 1'b0;
            end
        end else if (track && idx_hit(wb_en, wb_rd, held_idx)) begin
            byp_v <= 1'b1;
            byp_d <= wb_data;
        end
    end

    assign val = byp_v ? byp_d : rf_read;
`else
    logic unused_byp;

    assign unused_byp = ^{clk, rst, flush, capture, track, new_idx,
                          held_idx, wb_en, wb_rd, wb_data};
    assign val = rf_read;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: single-entry pipeline register between decode and
// execute with optional writeback bypass (OPERAND_FETCH_BYPASS_EN).
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic [REG_IDX_W-1:0] rf_r1,
    output logic [REG_IDX_W-1:0] rf_r2,
    output logic                 rf_r_en,
    input  logic [XLEN-1:0]      rf_r1_read,
    input  logic [XLEN-1:0]      rf_r2_read,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [CTRL_W-1:0]    out_ctrl
);

    state_t               state;
    side_t                side;
    logic [REG_IDX_W-1:0] held_rs1;
    logic [REG_IDX_W-1:0] held_rs2;
    logic                 accept;
    logic                 track;

    assign in_ready = !rst && !flush && ((state == ST_EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign rf_r_en  = accept;
    assign rf_r1    = in_rs1;
    assign rf_r2    = in_rs2;

    // A stalled bundle keeps absorbing writes to its sources.
    assign track = (state == ST_FULL) && !out_ready && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            side     <= '0;
            held_rs1 <= '0;
            held_rs2 <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            state     <= ST_FULL;
            side.rd   <= in_rd;
            side.imm  <= in_imm;
            side.pc   <= in_pc;
            side.ctrl <= in_ctrl;
            held_rs1  <= in_rs1;
            held_rs2  <= in_rs2;
        end else if ((state == ST_FULL) && out_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign out_valid = (state == ST_FULL);
    assign out_rd    = side.rd;
    assign out_imm   = side.imm;
    assign out_pc    = side.pc;
    assign out_ctrl  = side.ctrl;

    operand_bypass u_byp1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .capture  (accept),
        .track    (track),
        .new_idx  (in_rs1),
        .held_idx (held_rs1),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_read  (rf_r1_read),
        .val      (out_rs1_val)
    );

    operand_bypass u_byp2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .capture  (accept),
        .track    (track),
        .new_idx  (in_rs2),
        .held_idx (held_rs2),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_read  (rf_r2_read),
        .val      (out_rs2_val)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a register-file model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]      in_imm, in_pc;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [REG_IDX_W-1:0] rf_r1, rf_r2;
    logic                 rf_r_en;
    logic [XLEN-1:0]      rf_r1_read = '0;
    logic [XLEN-1:0]      rf_r2_read = '0;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_rs1_val, out_rs2_val;
    logic [REG_IDX_W-1:0] out_rd;
    logic [XLEN-1:0]      out_imm, out_pc;
    logic [CTRL_W-1:0]    out_ctrl;

    logic [XLEN-1:0] regs [32] = '{default: '0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file: one-cycle read latency, old data on same-edge write.
    always @(posedge clk) begin
        if (rf_r_en) begin
            rf_r1_read <= regs[rf_r1];
            rf_r2_read <= regs[rf_r2];
        end
        if (wb_en && wb_rd != 0) regs[wb_rd] <= wb_data;
    end

    operand_fetch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_r_en(rf_r_en),
        .rf_r1_read(rf_r1_read), .rf_r2_read(rf_r2_read),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
        .out_ctrl(out_ctrl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] pc);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_pc    = pc;
        in_rd    = rs1 + 5'd1;
        in_imm   = pc + 32'd8;
        in_ctrl  = pc[15:0];
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        drive(5'd3, 5'd4, 32'h40);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (rf_r_en !== 1'b0) begin
            errors++; $display("FAIL rst_rf_r_en: got %b expected 0", rf_r_en);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({out_rd, out_imm, out_pc, out_ctrl} !== '0) begin
            errors++;
            $display("FAIL rst_sideband: got %h/%h/%h/%h expected 0",
                     out_rd, out_imm, out_pc, out_ctrl);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        write_reg(5'd5, 32'h11);
        drive(5'd5, 5'd0, 32'h100);
        out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, rf_r_en, rf_r1} !== {1'b1, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL basic_issue: got rdy=%b en=%b r1=%0d expected 1 1 5",
                     in_ready, rf_r_en, rf_r1);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (out_rs1_val !== 32'h11 || out_rs2_val !== 32'h0) begin
            errors++;
            $display("FAIL basic_ops: got %h %h expected 00000011 00000000",
                     out_rs1_val, out_rs2_val);
        end
        checks++;
        if (out_pc !== 32'h100 || out_rd !== 5'd6 || out_imm !== 32'h108 ||
            out_ctrl !== 16'h0100) begin
            errors++;
            $display("FAIL basic_side: got pc=%h rd=%0d imm=%h ctrl=%h expected 100 6 108 0100",
                     out_pc, out_rd, out_imm, out_ctrl);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_same_edge();
        out_ready = 1'b0;
        drive(5'd5, 5'd0, 32'h110);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAB;
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        #1;
        checks++;
        if (out_rs1_val !== (BYP ? 32'hAB : 32'h11)) begin
            errors++;
            $display("FAIL same_edge_rs1: got %h expected %h",
                     out_rs1_val, BYP ? 32'hAB : 32'h11);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_stall_bypass();
        write_reg(5'd6, 32'h22);
        drive(5'd0, 5'd6, 32'h200);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rs2_val !== 32'h22) begin
            errors++;
            $display("FAIL stall_first: got v=%b rs2=%h expected 1 00000022",
                     out_valid, out_rs2_val);
        end
        write_reg(5'd6, 32'h77);
        checks++;
        if (out_rs2_val !== (BYP ? 32'h77 : 32'h22)) begin
            errors++;
            $display("FAIL stall_bypass: got %h expected %h",
                     out_rs2_val, BYP ? 32'h77 : 32'h22);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 ||
            out_rs2_val !== (BYP ? 32'h77 : 32'h22)) begin
            errors++;
            $display("FAIL stall_hold: got v=%b pc=%h rs2=%h expected 1 200 %h",
                     out_valid, out_pc, out_rs2_val, BYP ? 32'h77 : 32'h22);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_equal_and_zero();
        drive(5'd7, 5'd7, 32'h280);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h5A;
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        checks++;
        if (out_rs1_val !== (BYP ? 32'h5A : 32'h0) ||
            out_rs2_val !== (BYP ? 32'h5A : 32'h0)) begin
            errors++;
            $display("FAIL equal_capture: got %h %h expected %h",
                     out_rs1_val, out_rs2_val, BYP ? 32'h5A : 32'h0);
        end
        write_reg(5'd7, 32'h66);
        checks++;
        if (out_rs1_val !== (BYP ? 32'h66 : 32'h0) ||
            out_rs2_val !== (BYP ? 32'h66 : 32'h0)) begin
            errors++;
            $display("FAIL equal_track: got %h %h expected %h",
                     out_rs1_val, out_rs2_val, BYP ? 32'h66 : 32'h0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(5'd0, 5'd0, 32'h2C0);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        tick();
        wb_en = 1'b0;
        checks++;
        if (out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0) begin
            errors++;
            $display("FAIL zero_index: got %h %h expected 0 0",
                     out_rs1_val, out_rs2_val);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) write_reg(i[4:0], 32'h1000 + i);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(i[4:0], 5'd0, 32'h300 + 4 * i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h300 + 4 * i ||
                out_rs1_val !== 32'h1000 + i) begin
                errors++;
                $display("FAIL stream_out_%0d: got v=%b pc=%h rs1=%h expected 1 %h %h",
                         i, out_valid, out_pc, out_rs1_val, 32'h300 + 4 * i, 32'h1000 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(5'd5, 5'd0, 32'h400);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        drive(5'd6, 5'd0, 32'h404);
        #1;
        checks++;
        if (in_ready !== 1'b0 || rf_r_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: got rdy=%b en=%b expected 0 0", in_ready, rf_r_en);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_empty: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(5'd5, 5'd0, 32'h500);
        tick();
        rst = 1'b1;
        drive(5'd5, 5'd0, 32'h504);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: got %b expected 0", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_drop: got v=%b pc=%h expected 0 0", out_valid, out_pc);
        end
        out_ready = 1'b1;
        drive(5'd5, 5'd0, 32'h508);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h508 || out_rs1_val !== 32'hAB) begin
            errors++;
            $display("FAIL midrst_resume: got v=%b pc=%h rs1=%h expected 1 508 000000ab",
                     out_valid, out_pc, out_rs1_val);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_edge();
        test_stall_bypass();
        test_equal_and_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
